// File: rtl/sram_1rw_responder.sv
// sram_1rw_responder: single-port 1RW SRAM model answering an initiator's ram_* bus.
// Optional power-on clear sequence: define SRAM_RESP_CLEAR_EN.
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   ram_csb0, ram_web0   active-low chip select and write enable
//   ram_wmask0           byte write mask
//   ram_addr0, ram_din0  word address and write data
//   ram_dout0            registered read data
//   busy                 clear sequence running
//   err                  sticky error (out-of-range or request while busy)
//   rd_count, wr_count   saturating counts of accepted reads/writes
module sram_1rw_responder #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_csb0,
  input  logic              ram_web0,
  input  logic [3:0]        ram_wmask0,
  input  logic [ADDR_W-1:0] ram_addr0,
  input  logic [31:0]       ram_din0,
  output logic [31:0]       ram_dout0,
  output logic              busy,
  output logic              err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [IW-1:0] idx;
  logic          in_range;
  logic          req;
  logic          rd_ok;
  logic          wr_ok;

  assign idx      = ram_addr0[IW-1:0];
  assign in_range = {1'b0, ram_addr0} < LIMIT;
  assign req      = rst_n && !ram_csb0 && !busy;
  assign rd_ok    = req && in_range && ram_web0;
  assign wr_ok    = req && in_range && !ram_web0;

`ifdef SRAM_RESP_CLEAR_EN
  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  state_t        state;
  logic [IW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (state == CLEAR) begin
      ptr <= ptr + IW'(1);
      if (ptr == LAST)
        state <= IDLE;
    end
  end

  assign busy = (state == CLEAR);
`else
  assign busy = 1'b0;
`endif

  // Memory has no reset; only the clear sequence may zero it.
  always_ff @(posedge clk) begin
`ifdef SRAM_RESP_CLEAR_EN
    if (rst_n && state == CLEAR)
      mem[ptr] <= '0;
    else
`endif
    if (wr_ok) begin
      for (int b = 0; b < 4; b++)
        if (ram_wmask0[b])
          mem[idx][8*b +: 8] <= ram_din0[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_dout0 <= '0;
      err       <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else if (!ram_csb0) begin
      if (busy || !in_range)
        err <= 1'b1;
      if (!busy && !in_range && ram_web0)
        ram_dout0 <= '0;
      if (rd_ok) begin
        ram_dout0 <= mem[idx];
        if (rd_count != 16'hFFFF)
          rd_count <= rd_count + 16'd1;
      end
      if (wr_ok && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sram_1rw_responder.sv
// tb_sram_1rw_responder: random and directed stimulus vs. a behavioural model.
// Build with SRAM_RESP_CLEAR_EN to exercise the clear sequence.
module tb_sram_1rw_responder;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 9;
`ifdef SRAM_RESP_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ram_csb0 = 1'b1;
  logic              ram_web0 = 1'b1;
  logic [3:0]        ram_wmask0 = '0;
  logic [ADDR_W-1:0] ram_addr0 = '0;
  logic [31:0]       ram_din0 = '0;
  logic [31:0]       ram_dout0;
  logic              busy;
  logic              err;
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;

  sram_1rw_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_csb0(ram_csb0), .ram_web0(ram_web0),
    .ram_wmask0(ram_wmask0), .ram_addr0(ram_addr0),
    .ram_din0(ram_din0), .ram_dout0(ram_dout0),
    .busy(busy), .err(err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  bit [31:0] m_mem [DEPTH];
  bit        m_known [DEPTH];
  bit [31:0] m_dout;
  bit        m_dout_known;
  bit        m_err;
  int        m_rd;
  int        m_wr;
  int        busy_left;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input bit csb, input bit web, input bit [3:0] m,
                      input int a, input bit [31:0] d);
    ram_csb0   = csb;
    ram_web0   = web;
    ram_wmask0 = m;
    ram_addr0  = ADDR_W'(a);
    ram_din0   = d;
    @(posedge clk);
    if (!rst_n) begin
      m_dout = 0; m_dout_known = 1;
      m_err = 0; m_rd = 0; m_wr = 0;
      busy_left = CLR ? DEPTH : 0;
    end else if (busy_left > 0) begin
      m_mem[DEPTH - busy_left] = 0;
      m_known[DEPTH - busy_left] = 1;
      busy_left--;
      if (!csb) m_err = 1;
    end else if (!csb) begin
      if (a >= DEPTH) begin
        m_err = 1;
        if (web) begin m_dout = 0; m_dout_known = 1; end
      end else if (web) begin
        m_dout = m_mem[a];
        m_dout_known = m_known[a];
        m_rd = (m_rd < 65535) ? m_rd + 1 : 65535;
      end else begin
        for (int b = 0; b < 4; b++)
          if (m[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
        if (m == 4'hF) m_known[a] = 1;
        m_wr = (m_wr < 65535) ? m_wr + 1 : 65535;
      end
    end
    #1;
    if (m_dout_known) chk("dout", ram_dout0, m_dout);
    chk("err", 32'(err), 32'(m_err));
    chk("busy", 32'(busy), 32'(busy_left > 0));
    chk("rd_count", 32'(rd_count), 32'(m_rd));
    chk("wr_count", 32'(wr_count), 32'(m_wr));
  endtask

  task automatic idle();
    step(1, 1, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    idle();
    rst_n = 1;
    for (int i = 0; i < DEPTH + 4 && busy_left > 0; i++) idle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_known[i] = 0;
      m_mem[i] = 0;
    end
    busy_left = 0;
    do_reset();
    chk("rst_dout", ram_dout0, 32'h0);
    chk("rst_rd", 32'(rd_count), 32'h0);

    step(0, 0, 4'hF, 3, 32'h11223344);
    step(0, 1, 4'h0, 3, 0);
    chk("rd_a3", ram_dout0, 32'h11223344);

    step(0, 0, 4'hF, 7, 32'hAAAAAAAA);
    step(0, 0, 4'b0100, 7, 32'h00550000);
    step(0, 1, 4'h0, 7, 0);
    chk("byte_mask", ram_dout0, 32'hAA55AAAA);

    step(0, 0, 4'h0, 7, 32'hFFFFFFFF);
    step(0, 1, 4'h0, 7, 0);
    chk("mask0_keep", ram_dout0, 32'hAA55AAAA);
    chk("mask0_cnt", 32'(wr_count), 32'd4);

    step(0, 1, 4'h0, DEPTH, 0);
    chk("oor_dout", ram_dout0, 32'h0);
    chk("oor_err", 32'(err), 32'h1);
    chk("oor_rd", 32'(rd_count), 32'd3);
    idle();
    chk("err_sticky", 32'(err), 32'h1);

    step(0, 0, 4'hF, 5, 32'hFFFFFFFF);
    rst_n = 0;
    idle();
    rst_n = 1;
    step(0, 1, 4'h0, 5, 0);
    chk("busy_rd_err", 32'(err), CLR ? 32'h1 : 32'h0);
    for (int i = 0; i < DEPTH + 4 && busy_left > 0; i++) idle();
    chk("busy_done", 32'(busy), 32'h0);
    step(0, 1, 4'h0, 5, 0);
    chk("a5_after_rst", ram_dout0, CLR ? 32'h0 : 32'hFFFFFFFF);

    for (int i = 0; i < 3000; i++) begin
      int a;
      bit [31:0] d;
      a = $urandom_range(DEPTH + 3, 0);
      d = $urandom;
      if ($urandom_range(9, 0) == 0) idle();
      else if ($urandom_range(3, 0) == 0) begin
        step(0, 0, 4'($urandom), a, d);
        step(0, 1, 4'h0, a, 0);
      end else
        step(0, $urandom_range(1, 0) == 1, 4'($urandom), a, d);
    end

    do_reset();
    step(0, 0, 4'hF, 9, 32'hCAFEF00D);
    step(0, 1, 4'h0, 9, 0);
    chk("b2b", ram_dout0, 32'hCAFEF00D);
    for (int i = 0; i < 65537; i++) step(0, 1, 4'h0, 9, 0);
    chk("rd_sat", 32'(rd_count), 32'h0000FFFF);
    chk("sat_err", 32'(err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
